// File: rtl/stall_ctrl_pkg.sv
// Shared definitions for the MIPS hazard/stall controller: MDU latencies,
// the "operand not used" Tuse encoding, Tnew values per instruction class,
// and small helpers shared by the controller and its sub-blocks.
package stall_ctrl_pkg;

  // Default multiply/divide unit occupancy, in cycles after the start edge.
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  // Register number of the hard-wired zero register.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Tuse encoding: 3 means the D-stage instruction does not read the operand.
  // Tnew never exceeds 2, so "tuse < tnew" can never be true for it.
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Tnew per instruction class and stage.
  localparam logic [1:0] TNEW_ALU_E  = 2'd1;
  localparam logic [1:0] TNEW_LOAD_E = 2'd2;
  localparam logic [1:0] TNEW_LOAD_M = 2'd1;
  localparam logic [1:0] TNEW_READY  = 2'd0;

  // Kind of operation launched into the multiply/divide unit.
  typedef enum logic {
    MD_MULT = 1'b0,
    MD_DIV  = 1'b1
  } md_op_e;

  // One producer/consumer register-dependency check.
  // A stall is needed when the producer writes the register the consumer
  // reads, the register is not $0, and the value will not be forwardable
  // by the time the consumer needs it.
  function automatic logic reg_hazard(
    input logic [4:0] prod_a3,
    input logic       prod_we,
    input logic [1:0] prod_tnew,
    input logic [4:0] cons_src,
    input logic [1:0] cons_tuse
  );
    return prod_we
        && (prod_a3 == cons_src)
        && (cons_src != REG_ZERO)
        && (cons_tuse < prod_tnew);
  endfunction

  // 32-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/stall_ctrl_md_busy_cnt.sv
// Multiply/divide unit busy window. A start pulse loads the occupancy of the
// launched operation; the counter then runs down to zero and busy is high
// while it is non-zero. A new start always reloads, abandoning any
// operation still in flight.
module md_busy_cnt
  import stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic isDiv,
  output logic busy
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  md_op_e           op_kind;

  assign op_kind = isDiv ? MD_DIV : MD_MULT;

  // Next count: a start reloads with priority, otherwise run down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = (op_kind == MD_DIV) ? DIV_LOAD : MULT_LOAD;
    end else if (cnt_q != CNT_ZERO) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Countdown register; reset wins over a simultaneous start.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != CNT_ZERO);

endmodule

// File: rtl/stall_ctrl.sv
// Hazard and stall controller for the 5-stage MIPS pipeline. Compares the
// D-stage operand deadlines (Tuse) against the forwarding readiness (Tnew)
// of E and M, blocks MDU instructions while the multiply/divide unit is
// occupied, and keeps a saturating count of stalled cycles.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_TuseRs,
  input  logic [1:0]  D_TuseRt,
  input  logic        D_useMd,
  input  logic [4:0]  E_A3,
  input  logic        E_RegWrite,
  input  logic [1:0]  E_Tnew,
  input  logic [4:0]  M_A3,
  input  logic        M_RegWrite,
  input  logic [1:0]  M_Tnew,
  input  logic        E_start,
  input  logic        E_isDiv,
  output logic        stall,
  output logic        flush_E,
  output logic        busy,
  output logic [31:0] stall_count
);

  logic        hz_e_rs;
  logic        hz_e_rt;
  logic        hz_m_rs;
  logic        hz_m_rt;
  logic        hz_md;
  logic        md_busy;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // MDU occupancy window.
  md_busy_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_cnt (
    .clk   (clk),
    .reset (reset),
    .start (E_start),
    .isDiv (E_isDiv),
    .busy  (md_busy)
  );

  // Register dependencies of the D instruction on the E and M producers.
  always_comb begin
    hz_e_rs = reg_hazard(E_A3, E_RegWrite, E_Tnew, D_rs, D_TuseRs);
    hz_e_rt = reg_hazard(E_A3, E_RegWrite, E_Tnew, D_rt, D_TuseRt);
    hz_m_rs = reg_hazard(M_A3, M_RegWrite, M_Tnew, D_rs, D_TuseRs);
    hz_m_rt = reg_hazard(M_A3, M_RegWrite, M_Tnew, D_rt, D_TuseRt);
  end

  // An MDU instruction in D must wait while the unit is occupied, including
  // the cycle in which an operation is just launching from E.
  assign hz_md = D_useMd & (md_busy | E_start);

  // Freeze PC and IF/ID and bubble ID/EX in the same cycle as the hazard.
  assign stall   = hz_e_rs | hz_e_rt | hz_m_rs | hz_m_rt | hz_md;
  assign flush_E = stall;
  assign busy    = md_busy;

  // Next stall count: one more per stalled cycle, sticking at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) begin
      stall_cnt_d = sat_inc32(stall_cnt_q);
    end
  end

  // Stall-cycle counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Bench for stall_ctrl: directed cases followed by random traffic. The
// driver applies inputs on the falling edge and queues what the outputs
// must be in that cycle; a monitor pops and compares shortly afterwards.
module tb_stall_ctrl;
  import stall_ctrl_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs, D_rt, E_A3, M_A3;
  logic [1:0]  D_TuseRs, D_TuseRt, E_Tnew, M_Tnew;
  logic        D_useMd, E_RegWrite, M_RegWrite, E_start, E_isDiv;
  logic        stall, flush_E, busy;
  logic [31:0] stall_count;

  always #5 clk = ~clk;

  stall_ctrl #(
    .MULT_CYCLES (MC),
    .DIV_CYCLES  (DC),
    .CNT_W       (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .D_rs        (D_rs),
    .D_rt        (D_rt),
    .D_TuseRs    (D_TuseRs),
    .D_TuseRt    (D_TuseRt),
    .D_useMd     (D_useMd),
    .E_A3        (E_A3),
    .E_RegWrite  (E_RegWrite),
    .E_Tnew      (E_Tnew),
    .M_A3        (M_A3),
    .M_RegWrite  (M_RegWrite),
    .M_Tnew      (M_Tnew),
    .E_start     (E_start),
    .E_isDiv     (E_isDiv),
    .stall       (stall),
    .flush_E     (flush_E),
    .busy        (busy),
    .stall_count (stall_count)
  );

  typedef struct {
    int          cyc;
    logic        stall;
    logic        busy;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: the last cycle in which the MDU is still busy,
  // and the running stall total.
  int          cyc       = 0;
  int          busy_last = -1;
  logic [31:0] m_cnt     = 32'd0;

  // Expected stall for the current inputs, from the dependency rules.
  function automatic logic model_stall(input int c);
    logic [4:0] pa3[2];
    logic       pwe[2];
    int         ptn[2];
    logic [4:0] src[2];
    int         tuse[2];
    logic       s;
    pa3[0] = E_A3; pwe[0] = E_RegWrite; ptn[0] = int'(E_Tnew);
    pa3[1] = M_A3; pwe[1] = M_RegWrite; ptn[1] = int'(M_Tnew);
    src[0] = D_rs; tuse[0] = int'(D_TuseRs);
    src[1] = D_rt; tuse[1] = int'(D_TuseRt);
    s = 1'b0;
    for (int p = 0; p < 2; p++)
      for (int o = 0; o < 2; o++)
        if (pwe[p] && src[o] != 0 && pa3[p] == src[o] && tuse[o] < ptn[p])
          s = 1'b1;
    if (D_useMd && ((c <= busy_last) || E_start)) s = 1'b1;
    return s;
  endfunction

  // Queue this cycle's expectation (optional), then advance the model
  // across the rising edge.
  task automatic tick(input bit chk);
    exp_t e;
    logic s;
    s = model_stall(cyc);
    e.cyc = cyc; e.stall = s; e.busy = (cyc <= busy_last); e.cnt = m_cnt;
    if (chk) sb.push_back(e);
    @(posedge clk);
    if (reset) begin
      busy_last = -1;
      m_cnt     = 32'd0;
    end else begin
      if (s) m_cnt = (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 32'd1;
      if (E_start) busy_last = cyc + (E_isDiv ? DC : MC);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_inputs();
    reset = 1'b0;
    D_rs = 5'd0; D_rt = 5'd0; D_TuseRs = TUSE_NONE; D_TuseRt = TUSE_NONE;
    D_useMd = 1'b0;
    E_A3 = 5'd0; E_RegWrite = 1'b0; E_Tnew = TNEW_READY;
    M_A3 = 5'd0; M_RegWrite = 1'b0; M_Tnew = TNEW_READY;
    E_start = 1'b0; E_isDiv = 1'b0;
  endtask

  // Monitor: compare whatever the driver queued for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (stall !== e.stall) begin
          n_fail++;
          $display("FAIL stall cyc=%0d got=%b exp=%b", e.cyc, stall, e.stall);
        end
        n_checks++;
        if (flush_E !== e.stall) begin
          n_fail++;
          $display("FAIL flush_E cyc=%0d got=%b exp=%b", e.cyc, flush_E, e.stall);
        end
        n_checks++;
        if (busy !== e.busy) begin
          n_fail++;
          $display("FAIL busy cyc=%0d got=%b exp=%b", e.cyc, busy, e.busy);
        end
        n_checks++;
        if (stall_count !== e.cnt) begin
          n_fail++;
          $display("FAIL stall_count cyc=%0d got=%h exp=%h", e.cyc, stall_count, e.cnt);
        end
      end
    end
  end

  // Driver.
  initial begin
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    tick(1'b0);
    tick(1'b1);
    reset = 1'b0;
    tick(1'b1);

    // lw $1 in E, addu reading $1 in D.
    E_A3 = 5'd1; E_RegWrite = 1'b1; E_Tnew = TNEW_LOAD_E;
    D_rs = 5'd1; D_TuseRs = 2'd1;
    tick(1'b1);
    tick(1'b1);
    // Same producer targeting $0: never a hazard.
    E_A3 = 5'd0; D_rs = 5'd0;
    tick(1'b1);
    idle_inputs();

    // M load feeding rt: Tuse 0 stalls, Tuse 1 does not.
    M_A3 = 5'd5; M_RegWrite = 1'b1; M_Tnew = TNEW_LOAD_M;
    D_rt = 5'd5; D_TuseRt = 2'd0;
    tick(1'b1);
    D_TuseRt = 2'd1;
    tick(1'b1);
    D_TuseRt = TUSE_NONE;
    tick(1'b1);
    idle_inputs();

    // div launch with an MDU instruction waiting in D.
    D_useMd = 1'b1; E_start = 1'b1; E_isDiv = 1'b1;
    tick(1'b1);
    E_start = 1'b0; E_isDiv = 1'b0;
    for (int i = 0; i < 12; i++) tick(1'b1);
    idle_inputs();

    // mult launch, then reset during its third busy cycle.
    E_start = 1'b1;
    tick(1'b1);
    E_start = 1'b0; D_useMd = 1'b1;
    tick(1'b1);
    tick(1'b1);
    reset = 1'b1;
    tick(1'b1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b1);
    idle_inputs();

    // Restart while busy reloads the window.
    E_start = 1'b1; E_isDiv = 1'b1;
    tick(1'b1);
    tick(1'b1);
    E_isDiv = 1'b0;
    tick(1'b1);
    E_start = 1'b0;
    for (int i = 0; i < 7; i++) tick(1'b1);

    // Saturation of the stall counter.
    idle_inputs();
    E_A3 = 5'd3; E_RegWrite = 1'b1; E_Tnew = TNEW_ALU_E; D_rs = 5'd3; D_TuseRs = 2'd0;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    for (int i = 0; i < 4; i++) tick(1'b1);
    idle_inputs();
    tick(1'b1);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      reset      = ($urandom_range(0, 59) == 0);
      D_rs       = 5'($urandom_range(0, 3));
      D_rt       = 5'($urandom_range(0, 3));
      D_TuseRs   = 2'($urandom_range(0, 3));
      D_TuseRt   = 2'($urandom_range(0, 3));
      D_useMd    = ($urandom_range(0, 3) == 0);
      E_A3       = 5'($urandom_range(0, 3));
      E_RegWrite = 1'($urandom_range(0, 1));
      E_Tnew     = 2'($urandom_range(0, 2));
      M_A3       = 5'($urandom_range(0, 3));
      M_RegWrite = 1'($urandom_range(0, 1));
      M_Tnew     = 2'($urandom_range(0, 2));
      E_start    = ($urandom_range(0, 11) == 0);
      E_isDiv    = 1'($urandom_range(0, 1));
      tick(1'b1);
    end
    idle_inputs();
    tick(1'b1);

    // Every queued expectation must have been consumed.
    @(negedge clk);
    @(negedge clk);
    #3;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
